// File: rtl/serial_arith_unit.sv
// -----------------------------------------------------------------------------
// serial_arith_unit
//
// Purpose:
//   Byte-serial arithmetic unit. Two WIDTH-bit operands arrive LSB byte first.
//   The unit then runs one of four modes: add, subtract, add-with-carry or
//   accumulate. It streams back the WIDTH-bit result, LSB byte first, followed
//   by one status byte.
//
// Configuration macro:
//   SERIAL_ARITH_SAT_EN - when defined, results saturate instead of wrapping.
//                         add/adc/acc clamp to all-ones on carry.
//                         sub clamps to zero on borrow.
//                         Status bit5 reports that a clamp happened.
//
// Parameters:
//   WIDTH      operand/result width in bits (multiple of 8, 8..64)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   abort      synchronous clear of the current transaction
//   op_mode    00 add, 01 sub, 10 add-with-carry, 11 accumulate
//   in_data    operand byte, LSB byte first
//   in_valid   in_data valid
//   in_ready   unit accepts a byte this cycle
//   out_data   result/status byte
//   out_valid  out_data valid
//   out_ready  consumer takes out_data this cycle
//   busy       high unless idle in LOAD_A with no byte received
//
// Handshake:
//   A transfer happens on a rising edge where valid && ready. valid never
//   depends on ready. A producer holds its data stable while valid && !ready.
//   Here in_ready and out_valid depend only on the FSM state.
//
// Status byte:
//   bit0 carry (no-borrow for sub), bit1 signed overflow, bit2 result zero,
//   bits4:3 latched op_mode, bit5 saturated (0 without saturation), bits7:6 0.
//
// Debug visibility:
//   The FSM state is the enum signal 'state'. A checker can reach it
//   hierarchically.
// -----------------------------------------------------------------------------
module serial_arith_unit #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic [1:0] op_mode,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int NBYTES = WIDTH / 8;
  // The counter must reach NBYTES, which is the index of the status byte in SEND.
  localparam int CW = $clog2(NBYTES + 1);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ADC = 2'b10;
  localparam logic [1:0] MODE_ACC = 2'b11;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    CALC   = 2'b10,
    SEND   = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] a_q, b_q, acc_q, r_q;
  logic             carry_q;
  logic [1:0]       mode_q;
  logic [7:0]       status_q;

  // Strobes produced by the next-state logic
  logic ld_a, ld_b, latch_mode, do_calc;
  logic in_xfer, out_xfer;
  logic last_in, last_out;

  // Datapath signals for the CALC cycle
  logic [WIDTH-1:0] op_a, op_b, r_calc;
  logic [WIDTH:0]   sum;
  logic             cin, ovf, zero, sat;
  logic [7:0]       status_calc;

  // ---------------------------------------------------------------------------
  // Handshake outputs. Both depend only on the state.
  // ---------------------------------------------------------------------------
  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == SEND);
  assign busy      = !((state == LOAD_A) && (cnt == '0));

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign last_in  = (cnt == CW'(NBYTES - 1));
  assign last_out = (cnt == CW'(NBYTES));

  // ---------------------------------------------------------------------------
  // Arithmetic for the latched mode.
  // Subtraction is done as A + ~B + 1, so the carry out is the no-borrow flag.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a = a_q;
    op_b = b_q;
    cin  = 1'b0;
    case (mode_q)
      MODE_ADD: begin
        op_a = a_q;
        op_b = b_q;
        cin  = 1'b0;
      end
      MODE_SUB: begin
        op_a = a_q;
        op_b = ~b_q;
        cin  = 1'b1;
      end
      MODE_ADC: begin
        op_a = a_q;
        op_b = b_q;
        cin  = carry_q;
      end
      MODE_ACC: begin
        op_a = acc_q;
        op_b = a_q;
        cin  = 1'b0;
      end
      default: begin
        op_a = a_q;
        op_b = b_q;
        cin  = 1'b0;
      end
    endcase
  end

  assign sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};

  // Overflow is taken from the unclamped sum. This holds even when
  // saturation is enabled.
  assign ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    r_calc = sum[WIDTH-1:0];
    sat    = 1'b0;
`ifdef SERIAL_ARITH_SAT_EN
    if (mode_q == MODE_SUB) begin
      // A borrow means the true result was negative, so clamp to zero.
      if (!sum[WIDTH]) begin
        r_calc = '0;
        sat    = 1'b1;
      end
    end else begin
      if (sum[WIDTH]) begin
        r_calc = '1;
        sat    = 1'b1;
      end
    end
`else
    r_calc = sum[WIDTH-1:0];
    sat    = 1'b0;
`endif
  end

  assign zero        = (r_calc == '0);
  assign status_calc = {2'b00, sat, mode_q, zero, ovf, sum[WIDTH]};

  // ---------------------------------------------------------------------------
  // Output byte select. The output is zero outside SEND.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_data = 8'h00;
    if (state == SEND) begin
      if (last_out) begin
        out_data = status_q;
      end else begin
        out_data = r_q[int'(cnt)*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    latch_mode = 1'b0;
    do_calc    = 1'b0;

    case (state)
      LOAD_A: begin
        if (in_xfer) begin
          ld_a = 1'b1;
          if (last_in) begin
            latch_mode = 1'b1;
            cnt_nxt    = '0;
            // Accumulate needs only one operand, so it skips LOAD_B.
            state_nxt  = (op_mode == MODE_ACC) ? CALC : LOAD_B;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (in_xfer) begin
          ld_b = 1'b1;
          if (last_in) begin
            latch_mode = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = CALC;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      CALC: begin
        do_calc   = 1'b1;
        cnt_nxt   = '0;
        state_nxt = SEND;
      end
      SEND: begin
        if (out_xfer) begin
          if (last_out) begin
            cnt_nxt   = '0;
            state_nxt = LOAD_A;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = LOAD_A;
        cnt_nxt   = '0;
      end
    endcase

    // Abort drops the transaction. During CALC it also blocks the update of
    // R, acc and carry. The operand registers keep their contents.
    if (abort) begin
      state_nxt  = LOAD_A;
      cnt_nxt    = '0;
      ld_a       = 1'b0;
      ld_b       = 1'b0;
      latch_mode = 1'b0;
      do_calc    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_A;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      r_q      <= '0;
      carry_q  <= 1'b0;
      mode_q   <= MODE_ADD;
      status_q <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ld_a) begin
        a_q[int'(cnt)*8 +: 8] <= in_data;
      end
      if (ld_b) begin
        b_q[int'(cnt)*8 +: 8] <= in_data;
      end
      if (latch_mode) begin
        mode_q <= op_mode;
      end
      if (do_calc) begin
        r_q      <= r_calc;
        acc_q    <= r_calc;
        carry_q  <= sum[WIDTH];
        status_q <= status_calc;
      end
    end
  end

endmodule

// File: tb/tb_serial_arith_unit.sv
// -----------------------------------------------------------------------------
// tb_serial_arith_unit
//
// Bench for serial_arith_unit with WIDTH=16.
// Expected output bytes come from a reference model that uses plain integer
// arithmetic. The model tracks its own accumulator and carry flag.
// -----------------------------------------------------------------------------
module tb_serial_arith_unit;

  localparam int WIDTH  = 16;
  localparam int NBYTES = WIDTH / 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic [1:0] op_mode;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  // Reference model state
  longint m_acc;
  logic   m_carry;

  serial_arith_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .op_mode   (op_mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    m_acc   = 0;
    m_carry = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: computes one transaction and queues its output bytes
  // ---------------------------------------------------------------------------
  task automatic model_txn(input logic [1:0] mode, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
    longint full, mask, ua, ub, sa, sb, sacc, s, sv, r, smax, smin;
    logic carry, ovf, zero, sat;
    logic [7:0] status;
    full = longint'(1) << WIDTH;
    mask = full - 1;
    smax = (full >> 1) - 1;
    smin = -(full >> 1);
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = (ua > smax) ? ua - full : ua;
    sb   = (ub > smax) ? ub - full : ub;
    sacc = (m_acc > smax) ? m_acc - full : m_acc;
    sat  = 1'b0;
    case (mode)
      2'b00: begin s = ua + ub; sv = sa + sb; carry = (s >= full); r = s & mask; end
      2'b01: begin carry = (ua >= ub); r = (ua - ub + full) & mask; sv = sa - sb; end
      2'b10: begin
        s = ua + ub + (m_carry ? 1 : 0); sv = sa + sb + (m_carry ? 1 : 0);
        carry = (s >= full); r = s & mask;
      end
      default: begin s = m_acc + ua; sv = sacc + sa; carry = (s >= full); r = s & mask; end
    endcase
    ovf = (sv > smax) || (sv < smin);
`ifdef SERIAL_ARITH_SAT_EN
    if (mode == 2'b01 && !carry) begin r = 0; sat = 1'b1; end
    if (mode != 2'b01 && carry) begin r = mask; sat = 1'b1; end
`endif
    zero   = (r == 0);
    status = {2'b00, sat, mode, zero, ovf, carry};
    for (int i = 0; i < NBYTES; i++) exp_q.push_back(8'((r >> (8 * i)) & 255));
    exp_q.push_back(status);
    m_acc   = r;
    m_carry = carry;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks. Each is entered at a falling edge and returns at one.
  // ---------------------------------------------------------------------------
  task automatic drive_byte(input logic [7:0] d, input logic [1:0] m);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    op_mode  = m;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drive_operands(input logic [1:0] mode, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
    logic [1:0] m;
    for (int i = 0; i < NBYTES; i++) begin
      if (i == NBYTES - 1) m = (mode == 2'b11) ? 2'b11 : 2'($urandom_range(0, 2));
      else m = 2'($urandom_range(0, 3));
      drive_byte(a[8*i +: 8], m);
    end
    if (mode != 2'b11) begin
      for (int i = 0; i < NBYTES; i++) begin
        m = (i == NBYTES - 1) ? mode : 2'($urandom_range(0, 3));
        drive_byte(b[8*i +: 8], m);
      end
    end
    // Changes after the latch point must not affect this transaction
    op_mode = 2'($urandom_range(0, 3));
  endtask

  // stall: 0 always ready, 1 toggle, 2 random. hold_in offers junk input bytes.
  task automatic collect(input int stall, input bit hold_in);
    int n;
    logic [7:0] held;
    bit stalled;
    n = 0;
    stalled = 1'b0;
    held = 8'h00;
    while (exp_q.size() > 0 && n < 200) begin
      out_ready = (stall == 0) ? 1'b1 : (stall == 1) ? n[0] : 1'($urandom_range(0, 1));
      if (hold_in) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      if (out_valid) begin
        check("send_in_ready", in_ready, 0);
        if (stalled) check("stall_stable", out_data, held);
        if (out_ready) begin
          check("out_byte", out_data, exp_q.pop_front());
          stalled = 1'b0;
        end else begin
          held    = out_data;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (exp_q.size() != 0) begin
      check("out_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    check("valid_drop", out_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_txn(input logic [1:0] mode, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int stall, input bit hold_in);
    model_txn(mode, a, b);
    drive_operands(mode, a, b);
    // One cycle after the last byte is accepted, the unit is in CALC.
    check("calc_valid", out_valid, 0);
    check("calc_ready", in_ready, 0);
    check("calc_busy", busy, 1);
    @(negedge clk);
    check("first_valid", out_valid, 1);
    collect(stall, hold_in);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0] rm;
    rst       = 1'b1;
    abort     = 1'b0;
    op_mode   = 2'b00;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    m_acc     = 0;
    m_carry   = 1'b0;

    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 0);

    // Directed cases
    run_txn(2'b00, 16'h1234, 16'h00FF, 0, 1'b0);
    run_txn(2'b00, 16'hFFFF, 16'h0001, 0, 1'b0);
    run_txn(2'b10, 16'h0000, 16'h0000, 0, 1'b0);
    run_txn(2'b01, 16'h8000, 16'h0001, 0, 1'b0);
    run_txn(2'b01, 16'h0005, 16'h0007, 0, 1'b0);
    run_txn(2'b01, 16'h0000, 16'h8000, 0, 1'b0);
    run_txn(2'b00, 16'h7FFF, 16'h0001, 0, 1'b0);

    // Accumulate from a cleared accumulator
    do_reset();
    repeat (3) run_txn(2'b11, 16'h0010, 16'h0000, 0, 1'b0);

    // Backpressure, with input bytes offered during SEND
    run_txn(2'b00, 16'hA5C3, 16'h1111, 1, 1'b1);
    run_txn(2'b01, 16'h0100, 16'h0200, 2, 1'b1);

    // Abort after one A byte: the next bytes form a fresh transaction
    drive_byte(8'hEE, 2'b00);
    check("partial_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    run_txn(2'b00, 16'h0102, 16'h0304, 0, 1'b0);

    // Abort during CALC: no output, and acc and carry are kept
    drive_operands(2'b00, 16'h4444, 16'h4444);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_calc_valid", out_valid, 0);
    check("abort_calc_busy", busy, 0);
    run_txn(2'b11, 16'h0003, 16'h0000, 0, 1'b0);

    // Reset during SEND clears the accumulator
    drive_operands(2'b00, 16'h1000, 16'h2000);
    @(negedge clk);
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_acc   = 0;
    m_carry = 1'b0;
    check("rst_send_valid", out_valid, 0);
    check("rst_send_data", out_data, 8'h00);
    run_txn(2'b11, 16'h0001, 16'h0000, 0, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom_range(0, 3));
      run_txn(rm, WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 2),
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
